// File: rtl/arith_pkg.sv
// Shared types and constants for the GPIO-attached sequential multiply/divide unit.
// Optional feature macro: ARITH_DIV_EN (builds the restoring divider).
package arith_pkg;

  // GPIO chunk width in bits
  localparam int unsigned CHUNK = 32;

  // ctrl_reg command bit indices
  localparam int unsigned CTRL_LOAD  = 0;
  localparam int unsigned CTRL_START = 1;
  localparam int unsigned CTRL_CLEAR = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  // state_reg layout, MSB first: [31:16] iter, [15:6] zero, [5] unsup, [4] dz, [3] done, [2] busy, [1:0] state
  typedef struct packed {
    logic [15:0] iter;
    logic [9:0]  rsvd;
    logic        unsup;
    logic        dz;
    logic        done;
    logic        busy;
    state_e      state;
  } status_t;

endpackage

// File: rtl/arith_seq_core.sv
// Iterative datapath: radix-2 shift-add multiply and (with ARITH_DIV_EN) restoring divide.
// One bit per cycle for WIDTH cycles; the product/quotient-remainder share one 2*WIDTH register.
module arith_seq_core
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               clr_i,
`ifdef ARITH_DIV_EN
  input  mode_e              mode_i,
`endif
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_c_o,
  output logic [2*WIDTH-1:0] result_c_o,
  output logic [15:0]        iter_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] pq_q, pq_d, step_c;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     mul_sum_c;

  // Shift-add: add multiplicand into the upper half when the LSB is set, then shift right
  assign mul_sum_c = {1'b0, pq_q[2*WIDTH-1:WIDTH]}
                   + (pq_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

`ifdef ARITH_DIV_EN
  mode_e          mode_q, mode_d;
  logic [WIDTH:0] div_shift_c, div_trial_c;
  logic [WIDTH-1:0] div_rem_c;
  logic           div_qbit_c;

  // Restoring step: upper half is the partial remainder, lower half shifts dividend out / quotient in
  assign div_shift_c = pq_q[2*WIDTH-1:WIDTH-1];
  assign div_trial_c = div_shift_c - {1'b0, b_q};
  assign div_qbit_c  = ~div_trial_c[WIDTH];
  assign div_rem_c   = div_qbit_c ? div_trial_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
  assign step_c      = (mode_q == MODE_DIV) ? {div_rem_c, pq_q[WIDTH-2:0], div_qbit_c}
                                            : {mul_sum_c, pq_q[WIDTH-1:1]};
`else
  assign step_c = {mul_sum_c, pq_q[WIDTH-1:1]};
`endif

  // The final step is being taken this cycle; result_c_o is its outcome
  assign done_c_o   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign result_c_o = step_c;
  assign iter_o     = 16'(cnt_q);

  // Next-state: clear wins, then start loads operands, otherwise iterate while busy
  always_comb begin
    pq_d   = pq_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
`ifdef ARITH_DIV_EN
    mode_d = mode_q;
`endif
    if (clr_i) begin
      pq_d   = '0;
      b_d    = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
`ifdef ARITH_DIV_EN
      mode_d = MODE_MUL;
`endif
    end else if (start_i) begin
      pq_d   = {{WIDTH{1'b0}}, a_i};
      b_d    = b_i;
      cnt_d  = '0;
      busy_d = 1'b1;
`ifdef ARITH_DIV_EN
      mode_d = mode_i;
`endif
    end else if (busy_q) begin
      pq_d  = step_c;
      cnt_d = cnt_q + CNT_W'(1);
      if (done_c_o) busy_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef ARITH_DIV_EN
      mode_q <= MODE_MUL;
`endif
    end else begin
      pq_q   <= pq_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
`ifdef ARITH_DIV_EN
      mode_q <= mode_d;
`endif
    end
  end

endmodule

// File: rtl/gpio_arith_unit.sv
// GPIO front end for the sequential multiply/divide unit: command edge detection,
// chunked operand/result registers, control FSM and readback mux.
// Optional feature macro: ARITH_DIV_EN (divide mode; otherwise select[0]=1 reports unsupported).
module gpio_arith_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] select,
  input  logic [31:0] in_loc,
  input  logic [31:0] in_val,
  input  logic [31:0] ctrl_reg,
  output logic [31:0] out_loc,
  output logic [31:0] out_val,
  output logic [31:0] state_reg
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned NRES = 2 * N;

  state_e             state_q, state_d;
  logic [2:0]         ctrl_q;
  logic               load_e_c, start_e_c, clear_e_c;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dz_q, dz_d, unsup_q, unsup_d;
  logic               busy_q, done_q;
  logic [31:0]        out_loc_q, out_val_q, out_val_d;
  logic [15:0]        idx_c;
  logic               core_start_c, core_clr_c, core_done_c;
  logic [2*WIDTH-1:0] core_res_c;
  logic [15:0]        core_iter;
  status_t            status_c;
  logic               unused_bits;

  assign unused_bits = ^{select[31:1], in_loc[31:17], ctrl_reg[31:3]};

  // Rising-edge detection on the command bits against last cycle's sample
  assign load_e_c  = ctrl_reg[CTRL_LOAD]  & ~ctrl_q[CTRL_LOAD];
  assign start_e_c = ctrl_reg[CTRL_START] & ~ctrl_q[CTRL_START];
  assign clear_e_c = ctrl_reg[CTRL_CLEAR] & ~ctrl_q[CTRL_CLEAR];
  assign idx_c     = in_loc[15:0];

  arith_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst_n      (reset),
    .start_i    (core_start_c),
    .clr_i      (core_clr_c),
`ifdef ARITH_DIV_EN
    .mode_i     (mode_e'(select[0])),
`endif
    .a_i        (a_d),
    .b_i        (b_d),
    .done_c_o   (core_done_c),
    .result_c_o (core_res_c),
    .iter_o     (core_iter)
  );

  // Control FSM and operand/result next-state; clear beats load, load beats start
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    state_d      = state_q;
    dz_d         = dz_q;
    unsup_d      = unsup_q;
    core_start_c = 1'b0;
    core_clr_c   = 1'b0;
    if (clear_e_c) begin
      a_d        = '0;
      b_d        = '0;
      res_d      = '0;
      state_d    = ST_IDLE;
      dz_d       = 1'b0;
      unsup_d    = 1'b0;
      core_clr_c = 1'b1;
    end else begin
      if (load_e_c && (state_q != ST_RUN)) begin
        for (int k = 0; k < int'(N); k++) begin
          if (idx_c == 16'(k)) begin
            if (in_loc[16]) b_d[k*CHUNK +: CHUNK] = in_val;
            else            a_d[k*CHUNK +: CHUNK] = in_val;
          end
        end
      end
      if ((state_q == ST_RUN) && core_done_c) begin
        state_d = ST_DONE;
        res_d   = core_res_c;
      end
      if (start_e_c && (state_q != ST_RUN)) begin
        dz_d    = 1'b0;
        unsup_d = 1'b0;
`ifdef ARITH_DIV_EN
        if ((mode_e'(select[0]) == MODE_DIV) && (b_d == '0)) begin
          state_d    = ST_ERR;
          res_d      = {a_d, {WIDTH{1'b1}}};
          dz_d       = 1'b1;
          core_clr_c = 1'b1;
        end
`else
        if (mode_e'(select[0]) == MODE_DIV) begin
          state_d    = ST_ERR;
          res_d      = '0;
          unsup_d    = 1'b1;
          core_clr_c = 1'b1;
        end
`endif
        else begin
          state_d      = ST_RUN;
          core_start_c = 1'b1;
        end
      end
    end
  end

  // Readback mux over the result as it will stand next cycle; out-of-range index reads 0
  always_comb begin
    out_val_d = '0;
    for (int k = 0; k < int'(NRES); k++) begin
      if (idx_c == 16'(k)) out_val_d = res_d[k*CHUNK +: CHUNK];
    end
  end

  // State, operand, result, flag and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= '0;
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      dz_q      <= 1'b0;
      unsup_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_loc_q <= '0;
      out_val_q <= '0;
    end else begin
      ctrl_q    <= ctrl_reg[2:0];
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      dz_q      <= dz_d;
      unsup_q   <= unsup_d;
      busy_q    <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      out_loc_q <= {16'h0000, idx_c};
      out_val_q <= out_val_d;
    end
  end

  // Status word assembled from registered fields
  always_comb begin
    status_c       = '0;
    status_c.iter  = core_iter;
    status_c.unsup = unsup_q;
    status_c.dz    = dz_q;
    status_c.done  = done_q;
    status_c.busy  = busy_q;
    status_c.state = state_q;
  end

  assign state_reg = status_c;
  assign out_loc   = out_loc_q;
  assign out_val   = out_val_q;

endmodule

// File: tb/tb_gpio_arith_unit.sv
// Self-checking bench for gpio_arith_unit (WIDTH = 128), table-driven plus hand sequences.
module tb_gpio_arith_unit;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned N     = WIDTH / 32;
`ifdef ARITH_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] select, in_loc, in_val, ctrl_reg;
  logic [31:0] out_loc, out_val, state_reg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic               mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] exp_res;
    logic [31:0]        exp_st;
  } vec_t;

  vec_t vecs[$];

  gpio_arith_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .select    (select),
    .in_loc    (in_loc),
    .in_val    (in_val),
    .ctrl_reg  (ctrl_reg),
    .out_loc   (out_loc),
    .out_val   (out_val),
    .state_reg (state_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic on whole operands, final status word from the documented layout
  function automatic void model(input logic mode, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [2*WIDTH-1:0] res, output logic [31:0] st);
    logic [2*WIDTH-1:0] aw, bw;
    aw = {{WIDTH{1'b0}}, a};
    bw = {{WIDTH{1'b0}}, b};
    if (mode && !DIV_EN) begin
      res = '0;
      st  = 32'h0000_0023;
    end else if (mode && (b == '0)) begin
      res = {a, {WIDTH{1'b1}}};
      st  = 32'h0000_0013;
    end else if (mode) begin
      res = {a % b, a / b};
      st  = (32'(WIDTH) << 16) | 32'h0000_000A;
    end else begin
      res = aw * bw;
      st  = (32'(WIDTH) << 16) | 32'h0000_000A;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chunk(input logic op, input int idx, input logic [31:0] val);
    in_loc   = {15'b0, op, 16'(idx)};
    in_val   = val;
    ctrl_reg = 32'h1;
    tick();
    ctrl_reg = 32'h0;
    tick();
  endtask

  task automatic load_op(input logic op, input logic [WIDTH-1:0] v);
    for (int k = 0; k < int'(N); k++) load_chunk(op, k, v[k*32 +: 32]);
  endtask

  // Pulse a command, then step until the unit leaves RUN; optional mid-run events at given cycles
  task automatic run_op(input logic mode, input logic [31:0] ctrl_init, input int restart_at,
                        input int load_at, input int clear_at, output int n);
    select   = {31'b0, mode};
    ctrl_reg = ctrl_init;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      ctrl_reg = 32'h0;
      if (state_reg[1:0] != 2'd1) break;
      if (n == restart_at) ctrl_reg = 32'h2;
      if (n == load_at) begin
        in_loc   = 32'h0;
        in_val   = 32'hDEADBEEF;
        ctrl_reg = 32'h1;
      end
      if (n == clear_at) ctrl_reg = 32'h4;
    end
    ctrl_reg = 32'h0;
  endtask

  task automatic check_result(input string tag, input logic [2*WIDTH-1:0] exp);
    for (int k = 0; k <= int'(2*N); k++) begin
      in_loc = 32'(k);
      tick();
      chk($sformatf("%s_loc%0d", tag, k), out_loc, 32'(k));
      if (k < int'(2*N)) chk($sformatf("%s_chunk%0d", tag, k), out_val, exp[k*32 +: 32]);
      else               chk($sformatf("%s_oob", tag), out_val, 32'h0);
    end
  endtask

  initial begin
    vec_t v;
    int n;
    logic [WIDTH-1:0] ha, hb;
    logic [2*WIDTH-1:0] hres;
    logic [31:0] hst, nb0;

    reset = 1'b0; select = '0; in_loc = '0; in_val = '0; ctrl_reg = '0;
    #2;
    chk("reset_state", state_reg, 32'h0);
    chk("reset_val", out_val, 32'h0);
    chk("reset_loc", out_loc, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Directed rows from known results
    v = '{1'b0, 128'hFFFFFFFF, 128'd2, 256'h1_FFFFFFFE, 32'h0080_000A};
    vecs.push_back(v);
    v = '{1'b0, {WIDTH{1'b1}}, {WIDTH{1'b1}},
          256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001, 32'h0080_000A};
    vecs.push_back(v);
`ifdef ARITH_DIV_EN
    v = '{1'b1, 128'd100, 128'd7, {128'd2, 128'd14}, 32'h0080_000A};
    vecs.push_back(v);
    v = '{1'b1, 128'd5, 128'd0, {128'd5, {WIDTH{1'b1}}}, 32'h0000_0013};
    vecs.push_back(v);
`else
    v = '{1'b1, 128'd100, 128'd7, 256'd0, 32'h0000_0023};
    vecs.push_back(v);
    v = '{1'b1, 128'd5, 128'd0, 256'd0, 32'h0000_0023};
    vecs.push_back(v);
`endif
    // Random rows, expectations from the reference model
    for (int i = 0; i < 10; i++) begin
      v.mode = 1'($urandom_range(0, 1));
      for (int k = 0; k < int'(N); k++) begin
        v.a[k*32 +: 32] = $urandom;
        v.b[k*32 +: 32] = $urandom;
      end
      v.a = v.a >> $urandom_range(0, WIDTH - 1);
      v.b = v.b >> $urandom_range(0, WIDTH - 1);
      if ($urandom_range(0, 4) == 0) v.b = '0;
      model(v.mode, v.a, v.b, v.exp_res, v.exp_st);
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      load_op(1'b0, vecs[i].a);
      load_op(1'b1, vecs[i].b);
      run_op(vecs[i].mode, 32'h2, 0, 0, 0, n);
      chk($sformatf("v%0d_latency", i), 32'(n), (vecs[i].exp_st[1:0] == 2'd2) ? 32'(WIDTH + 1) : 32'd1);
      chk($sformatf("v%0d_status", i), state_reg, vecs[i].exp_st);
      check_result($sformatf("v%0d", i), vecs[i].exp_res);
    end

    // Start and load during RUN are ignored; operands survive for a rerun
    ha = {$urandom, $urandom, $urandom, $urandom};
    hb = {$urandom, $urandom, $urandom, $urandom | 32'h1};
    load_op(1'b0, ha);
    load_op(1'b1, hb);
    model(1'b0, ha, hb, hres, hst);
    run_op(1'b0, 32'h2, 10, 20, 0, n);
    chk("restart_latency", 32'(n), 32'(WIDTH + 1));
    chk("restart_status", state_reg, hst);
    check_result("restart", hres);
    run_op(1'b0, 32'h2, 0, 0, 0, n);
    chk("rerun_status", state_reg, hst);
    check_result("rerun", hres);

    // Clear edge at cycle 50 aborts the run and zeroes everything
    in_loc = 32'h0;
    run_op(1'b0, 32'h2, 0, 0, 50, n);
    chk("clear_cycle", 32'(n), 32'd51);
    chk("clear_status", state_reg, 32'h0);
    chk("clear_val", out_val, 32'h0);
    check_result("cleared", '0);
    run_op(1'b0, 32'h2, 0, 0, 0, n);
    chk("zero_op_status", state_reg, (32'(WIDTH) << 16) | 32'h0000_000A);
    check_result("zero_op", '0);

    // Load and start on the same edge: start sees the new chunk; out-of-range load ignored
    ha = {$urandom, $urandom, $urandom, $urandom};
    hb = {$urandom, $urandom, $urandom, $urandom};
    load_op(1'b0, ha);
    load_op(1'b1, hb);
    load_chunk(1'b0, N, 32'hFFFFFFFF);
    nb0 = $urandom | 32'h1;
    hb[31:0] = nb0;
    model(1'b0, ha, hb, hres, hst);
    in_loc = {15'b0, 1'b1, 16'h0};
    in_val = nb0;
    run_op(1'b0, 32'h3, 0, 0, 0, n);
    chk("ldstart_latency", 32'(n), 32'(WIDTH + 1));
    check_result("ldstart", hres);

    // Clear and start on the same edge: clear wins
    ctrl_reg = 32'h6;
    tick();
    ctrl_reg = 32'h0;
    chk("clear_beats_start", state_reg, 32'h0);
    tick();

    // Asynchronous reset mid-run
    in_loc   = 32'h3;
    select   = 32'h0;
    ctrl_reg = 32'h2;
    tick();
    ctrl_reg = 32'h0;
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", state_reg, 32'h0);
    chk("async_rst_val", out_val, 32'h0);
    chk("async_rst_loc", out_loc, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("post_rst_idle", state_reg, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
